// File: rtl/fu_writeback_scheduler_pkg.sv
// Shared definitions for the functional-unit writeback scheduler: unit ids in
// base priority order, default sizing and a width helper.
package fu_writeback_scheduler_pkg;

  typedef enum logic [3:0] {
    FU_FSQRT    = 4'd0,
    FU_DIV      = 4'd1,
    FU_FDIV     = 4'd2,
    FU_R4       = 4'd3,
    FU_FMUL     = 4'd4,
    FU_FADD_SUB = 4'd5,
    FU_MUL      = 4'd6,
    FU_FPU      = 4'd7,
    FU_ALU      = 4'd8
  } fu_id_t;

  localparam int unsigned N_FU    = 9;
  localparam int unsigned AGE_MAX = 7;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_writeback_scheduler_age_counter.sv
// Per-requester saturating wait counter; flags when a pending result has been
// passed over long enough to override base priority.
module wb_age_counter
  import fu_writeback_scheduler_pkg::*;
#(
  parameter int unsigned MAX_AGE = AGE_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid,
  input  logic grant,
  input  logic flush,
  output logic saturated
);

  localparam int unsigned AGE_W = idx_w(MAX_AGE + 1);

  logic [AGE_W-1:0] age_q, age_d;

  assign saturated = (age_q == AGE_W'(MAX_AGE));

  always_comb begin
    age_d = age_q;
    if (flush || grant || !valid) begin
      age_d = '0;
    end else if (!saturated) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/fu_writeback_scheduler.sv
// Age-aware arbiter feeding the single EXE/MEM write port through one
// registered valid/ready slot.
module fu_writeback_scheduler
  import fu_writeback_scheduler_pkg::*;
#(
  parameter  int unsigned N_REQ   = N_FU,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned RD_W    = 5,
  parameter  int unsigned AGE_MAX = fu_writeback_scheduler_pkg::AGE_MAX,
  localparam int unsigned SRC_W   = idx_w(N_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0][RD_W-1:0]   req_rd,
  input  logic [N_REQ-1:0]             req_fp,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         wb_valid,
  output logic [DATA_W-1:0]            wb_data,
  output logic [RD_W-1:0]              wb_rd,
  output logic                         wb_fp,
  output logic [SRC_W-1:0]             wb_src,
  input  logic                         wb_ready
);

  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              wb_fp_q, wb_fp_d;
  logic [SRC_W-1:0]  wb_src_q, wb_src_d;

  logic [N_REQ-1:0]  sat;
  logic [N_REQ-1:0]  grant_oh;
  logic [SRC_W-1:0]  gnt_idx;
  logic              found_sat;
  logic              found_any;
  logic              slot_free;
  logic              fire;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_age
    wb_age_counter #(
      .MAX_AGE(AGE_MAX)
    ) u_age (
      .clk      (clk),
      .reset_n  (reset_n),
      .valid    (req_valid[gi]),
      .grant    (grant_oh[gi]),
      .flush    (flush),
      .saturated(sat[gi])
    );
  end

  // Saturated requesters are searched first; plain fixed priority otherwise.
  always_comb begin
    gnt_idx   = '0;
    found_sat = 1'b0;
    found_any = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && sat[i] && !found_sat) begin
        gnt_idx   = SRC_W'(i);
        found_sat = 1'b1;
      end
    end
    if (!found_sat) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !found_any) begin
          gnt_idx   = SRC_W'(i);
          found_any = 1'b1;
        end
      end
    end
  end

  assign slot_free = !wb_valid_q || wb_ready;
  assign fire      = slot_free && !flush && (|req_valid);

  always_comb begin
    grant_oh = '0;
    if (fire) begin
      grant_oh[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = grant_oh;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_fp_d    = wb_fp_q;
    wb_src_d   = wb_src_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (fire) begin
      wb_valid_d = 1'b1;
      wb_data_d  = req_data[gnt_idx];
      wb_rd_d    = req_rd[gnt_idx];
      wb_fp_d    = req_fp[gnt_idx];
      wb_src_d   = gnt_idx;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_fp_q    <= 1'b0;
      wb_src_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_fp_q    <= wb_fp_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_fp    = wb_fp_q;
  assign wb_src   = wb_src_q;

endmodule
